key_expander: RTL and testbench
===============================

KEY_EXPANDER -- requirements
Module: key_expander

Interface
REQ-001 SHALL provide parameter KEY_BITS, default 128, AES cipher key length; legal values 128, 192, 256; NK=KEY_BITS/32, NR=NK+6 derived.
REQ-002 SHALL provide ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  request new expansion; sampled only when idle.
REQ-005 key  in  KEY_BITS  cipher key, w[0] in MSBs; captured on accepted start.
REQ-006 rk_valid  out  1  round key present on rk_data.
REQ-007 rk_ready  in  1  consumer accepts rk_data when high with rk_valid.
REQ-008 rk_data  out  128  round key, word 4r in MSBs.
REQ-009 rk_index  out  4  round number r of rk_data, 0..NR.
REQ-010 busy  out  1  high from accepted start until final round key accepted.
REQ-011 done  out  1  one-cycle pulse the cycle after round key NR is accepted.

Function
REQ-012 SHALL implement FIPS-197 key expansion, producing words w[0..4*(NR+1)-1], one word per clock when not stalled.
REQ-013 w[i]=key word i for i<NK; otherwise w[i]=w[i-NK] xor temp, temp derived from w[i-1].
REQ-014 temp: i mod NK=0 -> SubWord(RotWord(w[i-1])) xor {rcon,24'h0}; NK=8 and i mod 8=4 -> SubWord(w[i-1]); else w[i-1].
REQ-015 rcon generated internally: 8'h01 on start, advanced by GF(2^8) xtime (poly 8'h1B) after each i mod NK=0 word; no rcon input.
REQ-016 SHALL hold last NK words in a sliding window register; no full-schedule storage.
REQ-017 SubWord SHALL use four combinational AES S-box lookups, one word per cycle.
REQ-018 Words assembled four at a time; after the 4th word of group r, rk_data=w[4r..4r+3], rk_index=r, rk_valid=1.
REQ-019 Start accepted at edge E: w[0] generated at E+1, round key r valid E+4r+4 absent stall; round key NR valid E+4*NR+4.
REQ-020 rk_valid, rk_data, rk_index SHALL remain stable until rk_valid&&rk_ready.
REQ-021 Word generation SHALL continue while rk_valid is pending until the next group's 4 words are assembled; it then stalls, losing no word, until the pending key is accepted.
REQ-022 When a pending key is accepted in the same cycle the next group completes, the new key SHALL load in that cycle with no bubble (full throughput with rk_ready held high).
REQ-023 FSM states: IDLE (busy=0) -> RUN on start; RUN -> DRAIN after word 4*NR+3 generated; DRAIN -> IDLE on acceptance of round key NR, pulsing done.
REQ-024 start while busy SHALL be ignored; key not recaptured.
REQ-025 start and final acceptance in the same cycle: start ignored; new start accepted no earlier than the cycle after done.
REQ-026 rk_index SHALL never exceed NR; no output after round key NR until next start.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, rk_valid=0, rk_data=0, rk_index=0, busy=0, done=0, rcon=8'h01, window cleared.
REQ-028 Reset mid-expansion SHALL abort without a done pulse; start with rst_n=0 ignored.

Verification
REQ-029 KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk_index 0 data = key at E+4; rk_index 1 = a0fafe1788542cb123a339392a6c7605; rk_index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at E+44; done at E+45.
REQ-030 KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk 0 = 603deb1015ca71be2b73aef0857d7781, rk 1 = 1f352c073b6108d72d9810a30914dff4, rk 2 = 9ba354118e6925afa51a8b5f2067fcde, rk 14 = fe4890d1e6188d0b046df344706c631e.
REQ-031 KEY_BITS=128, rk_ready random (~50%) -> same 11 keys in order, each held stable while unaccepted, no duplicate or skipped rk_index.
REQ-032 KEY_BITS=128, pulse start again at E+10 with a different key -> ignored; outputs match REQ-029.
REQ-033 Assert rst_n=0 at E+20 -> next cycle rk_valid=0, busy=0, rk_data=0, no done; fresh start then reproduces REQ-029.
REQ-034 KEY_BITS=192, FIPS-197 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 round keys, rk 12 = e98ba06f448c773c8ecc720401002202.

Source files
------------

// File: rtl/key_expander.sv
// AES key expansion engine: one schedule word per clock, emitted as 128-bit
// round keys over a valid/ready handshake. Only the last NK words are kept.
module key_expander #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [3:0]          rk_index,
    output logic                busy,
    output logic                done
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam logic [5:0] LAST_IDX = 6'(4 * NR + 3);
    localparam logic [3:0] NK_M1    = 4'(NK - 1);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t      r_state;
    logic [31:0] r_win [NK];   // r_win[0] = w[i-NK] ... r_win[NK-1] = w[i-1]
    logic [95:0] r_grp;        // first three words of the group being built
    logic [5:0]  r_idx;        // index i of the next word to produce
    logic [3:0]  r_mod;        // i mod NK
    logic [7:0]  r_rcon;
    logic        r_valid;
    logic [127:0] r_data;
    logic [3:0]  r_index;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_prev;
    logic [31:0] w_old;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub_out;
    logic [31:0] w_temp;
    logic [31:0] w_word;
    logic        w_first;
    logic        w_accept;
    logic        w_gen;
    logic [7:0]  w_rcon_next;

    assign w_prev   = r_win[NK-1];
    assign w_old    = r_win[0];
    assign w_first  = (r_idx < 6'(NK));
    assign w_accept = r_valid && rk_ready;
    // The fourth word of a group needs the output slot; hold it back while a key is still unaccepted.
    assign w_gen    = (r_state == S_RUN) &&
                      !((r_idx[1:0] == 2'd3) && r_valid && !rk_ready);
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    // RotWord only on the rcon steps; other SubWord uses see w[i-1] unrotated.
    assign w_sub_in = (r_mod == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign w_sub_out[8*gi +: 8] = SBOX[w_sub_in[8*gi +: 8]];
        end
    endgenerate

    // Select the temp word for the current schedule position.
    always_comb begin
        w_temp = w_prev;
        if (r_mod == 4'd0) begin
            w_temp = w_sub_out ^ {r_rcon, 24'h000000};
        end else if ((NK == 8) && (r_mod == 4'd4)) begin
            w_temp = w_sub_out;
        end
    end

    // The key words are preloaded into the window and rotated out first, so after
    // NK steps the window naturally holds w[0..NK-1] in order.
    assign w_word = w_first ? w_old : (w_old ^ w_temp);

    assign rk_valid = r_valid;
    assign rk_data  = r_data;
    assign rk_index = r_index;
    assign busy     = r_busy;
    assign done     = r_done;

    // Control FSM, word generator, group assembly and output handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            for (int k = 0; k < NK; k++) begin
                r_win[k] <= '0;
            end
            r_grp   <= '0;
            r_idx   <= '0;
            r_mod   <= '0;
            r_rcon  <= 8'h01;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NK; k++) begin
                            r_win[k] <= key[KEY_BITS-1-32*k -: 32];
                        end
                        r_idx   <= '0;
                        r_mod   <= '0;
                        r_rcon  <= 8'h01;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_gen) begin
                        for (int k = 0; k < NK-1; k++) begin
                            r_win[k] <= r_win[k+1];
                        end
                        r_win[NK-1] <= w_word;
                        r_idx <= r_idx + 6'd1;
                        r_mod <= (r_mod == NK_M1) ? 4'd0 : r_mod + 4'd1;
                        if (!w_first && (r_mod == 4'd0)) begin
                            r_rcon <= w_rcon_next;
                        end
                        r_grp <= {r_grp[63:0], w_word};
                        if (r_idx[1:0] == 2'd3) begin
                            r_data  <= {r_grp, w_word};
                            r_index <= r_idx[5:2];
                            r_valid <= 1'b1;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_accept) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_expander.sv
// Bench for key_expander: three key sizes, a scoreboard fed by an independent
// key-schedule model, directed timing/abort/ignored-start steps.
module tb_key_expander;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         rk_ready;
    logic [255:0] key_in;
    logic         start_v [3];
    logic         v  [3];
    logic         b  [3];
    logic         dn [3];
    logic [127:0] d  [3];
    logic [3:0]   ix [3];

    key_expander #(.KEY_BITS(128)) u_k128 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .key(key_in[255:128]),
        .rk_valid(v[0]), .rk_ready(rk_ready), .rk_data(d[0]), .rk_index(ix[0]),
        .busy(b[0]), .done(dn[0]));
    key_expander #(.KEY_BITS(192)) u_k192 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .key(key_in[255:64]),
        .rk_valid(v[1]), .rk_ready(rk_ready), .rk_data(d[1]), .rk_index(ix[1]),
        .busy(b[1]), .done(dn[1]));
    key_expander #(.KEY_BITS(256)) u_k256 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .key(key_in),
        .rk_valid(v[2]), .rk_ready(rk_ready), .rk_data(d[2]), .rk_index(ix[2]),
        .busy(b[2]), .done(dn[2]));

    int           sel = 0;
    logic         m_valid, m_busy, m_done;
    logic [127:0] m_data;
    logic [3:0]   m_index;

    always_comb begin
        m_valid = v[sel];
        m_busy  = b[sel];
        m_done  = dn[sel];
        m_data  = d[sel];
        m_index = ix[sel];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] tb_sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] bb);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int j = 0; j < 8; j++) begin
            if (bb[j]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] t = {a, a};
        t = t << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] a);
        return {tb_sbox[a[31:24]], tb_sbox[a[23:16]], tb_sbox[a[15:8]], tb_sbox[a[7:0]]};
    endfunction

    logic [131:0] exp_q [$];

    task automatic model_push(input int nk, input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = k[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % 8 == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) begin
            exp_q.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
        end
    endtask

    // ---------------- monitor ----------------
    int           cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           nr_sel = 10;
    int           t_start, t_first, t_last, t_done, n_done;
    logic [127:0] got [16];
    bit           p_pend = 1'b0;
    logic [131:0] p_val;
    logic [131:0] e_item;

    always @(negedge clk) begin
        if (rst_n) begin
            if (p_pend) chk("hold_stable", {m_valid, m_index, m_data}, {1'b1, p_val});
            if (m_valid && rk_ready) begin
                chk("key_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e_item = exp_q.pop_front();
                    chk("round_key", {m_index, m_data}, e_item);
                end
                got[m_index] = m_data;
            end
            if (m_valid && m_index == 4'd0 && t_first < 0) t_first = cyc;
            if (m_valid && m_index == 4'(nr_sel) && t_last < 0) t_last = cyc;
            if (m_done) begin
                n_done++;
                t_done = cyc;
            end
            p_pend = m_valid && !rk_ready;
            p_val  = {m_index, m_data};
        end else begin
            p_pend = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_ready = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) rk_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic launch(input int s, input logic [255:0] k);
        int nk;
        nk = (s == 0) ? 4 : (s == 1) ? 6 : 8;
        sel = s;
        nr_sel = nk + 6;
        exp_q.delete();
        for (int j = 0; j < 16; j++) got[j] = '0;
        t_first = -1; t_last = -1; t_done = -1; n_done = 0;
        model_push(nk, k);
        key_in = k;
        start_v[s] = 1'b1;
        tick();
        start_v[s] = 1'b0;
        t_start = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!m_done && n < budget) begin
            tick();
            n++;
        end
        chk(tag, m_done, 1'b1);
        tick();
    endtask

    logic [255:0] K128, K192, K256;

    initial begin
        K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        for (int s = 0; s < 3; s++) start_v[s] = 1'b0;
        rk_ready = 1'b1;
        key_in   = K128;
        rst_n    = 1'b0;
        build_sbox();

        // Reset with start held: nothing may begin.
        start_v[0] = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", {v[0], b[0], dn[0], ix[0], d[0]}, '0);
        start_v[0] = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("reset_start_ignored", b[0], 1'b0);

        // AES-128, full throughput, start coinciding with final acceptance.
        launch(0, K128);
        chk("busy_after_start", m_busy, 1'b1);
        for (int n = 0; n < 60 && !(m_valid && m_index == 4'd10); n++) tick();
        chk("final_key_seen", {m_valid, m_index}, {1'b1, 4'd10});
        start_v[0] = 1'b1;
        key_in = ~K128;
        tick();
        start_v[0] = 1'b0;
        chk("done_pulse", {m_done, m_busy}, 2'b10);
        tick();
        chk("start_at_accept_ignored", {m_done, m_busy, m_valid}, 3'b000);
        chk("t_first", t_first - t_start, 4);
        chk("t_last", t_last - t_start, 44);
        chk("t_done", t_done - t_start, 45);
        chk("done_count", n_done, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("aes128_rk0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("aes128_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("aes128_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Start while busy must be ignored.
        launch(0, K128);
        repeat (9) tick();
        key_in = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        wait_done("busy_start_done", 100);
        chk("busy_start_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("busy_start_t_last", t_last - t_start, 44);
        chk("busy_start_queue", exp_q.size(), 0);
        chk("busy_start_done_count", n_done, 1);

        // Random back-pressure.
        rnd_ready = 1'b1;
        launch(0, K128);
        wait_done("random_ready_done", 600);
        rnd_ready = 1'b0;
        rk_ready  = 1'b1;
        chk("random_queue", exp_q.size(), 0);
        chk("random_done_count", n_done, 1);
        chk("random_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Abort mid-expansion, then a clean rerun.
        launch(0, K128);
        repeat (19) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_outputs", {m_valid, m_busy, m_done, m_index, m_data}, '0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("abort_no_done", n_done, 0);
        chk("abort_idle", {m_valid, m_busy}, 2'b00);
        launch(0, K128);
        wait_done("rerun_done", 100);
        chk("rerun_t_first", t_first - t_start, 4);
        chk("rerun_t_done", t_done - t_start, 45);
        chk("rerun_queue", exp_q.size(), 0);
        chk("rerun_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-256.
        launch(2, K256);
        wait_done("aes256_done", 100);
        chk("aes256_queue", exp_q.size(), 0);
        chk("aes256_t_last", t_last - t_start, 60);
        chk("aes256_rk0", got[0], 128'h603deb1015ca71be2b73aef0857d7781);
        chk("aes256_rk1", got[1], 128'h1f352c073b6108d72d9810a30914dff4);
        chk("aes256_rk2", got[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        chk("aes256_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // AES-192.
        launch(1, K192);
        wait_done("aes192_done", 100);
        chk("aes192_queue", exp_q.size(), 0);
        chk("aes192_t_last", t_last - t_start, 52);
        chk("aes192_rk0", got[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
        chk("aes192_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
